// File: rtl/if_stage_multi.sv
// ---------------------------------------------------------------------------
// if_stage_multi
//
// Instruction-fetch stage with several outstanding instruction-SRAM reads.
// Returned instructions go into a small fetch queue ahead of ID. When the
// stage is redirected, it does not wait for the bus to drain. Responses that
// belong to requests issued before the redirect are counted as stale and
// dropped when they come back.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   wb_flush/wb_target  writeback redirect (exception/ertn/refetch), wins
//   br_stall            unresolved branch in ID: no issue, br_taken ignored
//   br_taken/br_target  branch redirect from ID
//   ds_allowin          ID accepts the queue head this cycle
//   fs_to_ds_valid/bus  queue head, bus = {adef, inst[31:0], pc[31:0]}
//   inst_sram_*         SRAM-like request/addr_ok/data_ok instruction port
// ---------------------------------------------------------------------------
module if_stage_multi #(
  parameter logic [31:0] RESET_PC        = 32'h1C00_0000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          QUEUE_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_flush,
  input  logic [31:0] wb_target,
  input  logic        br_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int FW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int SW = ((OW > QW) ? OW : QW) + 1;

  // Architectural state
  logic [31:0]   fetch_pc_q;
  logic [OW-1:0] out_cnt_q;
  logic [OW-1:0] discard_cnt_q;
  logic          adef_stop_q;

  // PCs of in-flight requests, in issue order
  logic [31:0]   pend_mem [MAX_OUTSTANDING];
  logic [PW-1:0] pend_wr_q;
  logic [PW-1:0] pend_rd_q;

  // Fetch queue
  logic [64:0]   q_mem [QUEUE_DEPTH];
  logic [FW-1:0] q_wr_q;
  logic [FW-1:0] q_rd_q;
  logic [QW-1:0] q_cnt_q;

  // Combinational control
  logic          redirect_s;
  logic [31:0]   target_s;
  logic [OW-1:0] live_s;
  logic          q_full_s;
  logic          issue_s;
  logic          hs_s;
  logic          resp_s;
  logic          keep_s;
  logic          adef_s;
  logic          valid_s;
  logic          pop_s;
  logic          push_s;
  logic [64:0]   push_data_s;

  function automatic logic [PW-1:0] pend_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  function automatic logic [FW-1:0] q_next(input logic [FW-1:0] p);
    return (p == FW'(QUEUE_DEPTH - 1)) ? {FW{1'b0}} : p + FW'(1);
  endfunction

  // Redirect, issue, response and queue control decisions
  always_comb begin
    redirect_s = wb_flush | (br_taken & ~br_stall);
    target_s   = wb_flush ? wb_target : br_target;
    live_s     = out_cnt_q - discard_cnt_q;
    q_full_s   = (q_cnt_q == QW'(QUEUE_DEPTH));
    // Space is reserved in the queue for every live request, so a response
    // never finds the queue full.
    issue_s    = ~reset & ~redirect_s & ~br_stall & ~adef_stop_q
               & (fetch_pc_q[1:0] == 2'b00)
               & (out_cnt_q < OW'(MAX_OUTSTANDING))
               & ((SW'(live_s) + SW'(q_cnt_q)) < SW'(QUEUE_DEPTH));
    hs_s       = issue_s & inst_sram_addr_ok;
    // data_ok with nothing outstanding is a bus protocol error; ignore it
    resp_s     = ~reset & inst_sram_data_ok & (out_cnt_q != {OW{1'b0}});
    // A response in the redirect cycle is stale as well
    keep_s     = resp_s & ~redirect_s & (discard_cnt_q == {OW{1'b0}});
    // Misaligned PC: raise ADEF only once everything older is in the queue
    adef_s     = ~reset & ~redirect_s & (fetch_pc_q[1:0] != 2'b00) & ~adef_stop_q
               & (live_s == {OW{1'b0}}) & ~q_full_s;
    valid_s    = ~reset & (q_cnt_q != {QW{1'b0}}) & ~wb_flush;
    pop_s      = valid_s & ds_allowin & ~redirect_s;
    push_s     = keep_s | adef_s;
    if (adef_s) begin
      push_data_s = {1'b1, 32'h0000_0000, fetch_pc_q};
    end else begin
      push_data_s = {1'b0, inst_sram_rdata, pend_mem[pend_rd_q]};
    end
  end

  // Fetch PC, counters, ADEF latch and FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      out_cnt_q     <= {OW{1'b0}};
      discard_cnt_q <= {OW{1'b0}};
      adef_stop_q   <= 1'b0;
      pend_wr_q     <= {PW{1'b0}};
      pend_rd_q     <= {PW{1'b0}};
      q_wr_q        <= {FW{1'b0}};
      q_rd_q        <= {FW{1'b0}};
      q_cnt_q       <= {QW{1'b0}};
    end else begin
      if (redirect_s) begin
        fetch_pc_q <= target_s;
      end else if (hs_s) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_q <= fetch_pc_q;
      end

      adef_stop_q <= redirect_s ? 1'b0 : (adef_stop_q | adef_s);
      out_cnt_q   <= out_cnt_q + OW'(hs_s) - OW'(resp_s);

      if (redirect_s) begin
        discard_cnt_q <= out_cnt_q - OW'(resp_s);
      end else if (resp_s && (discard_cnt_q != {OW{1'b0}})) begin
        discard_cnt_q <= discard_cnt_q - OW'(1);
      end else begin
        discard_cnt_q <= discard_cnt_q;
      end

      // The pending-PC FIFO survives redirects: stale responses still pop it
      pend_wr_q <= hs_s   ? pend_next(pend_wr_q) : pend_wr_q;
      pend_rd_q <= resp_s ? pend_next(pend_rd_q) : pend_rd_q;

      if (redirect_s) begin
        q_wr_q  <= {FW{1'b0}};
        q_rd_q  <= {FW{1'b0}};
        q_cnt_q <= {QW{1'b0}};
      end else begin
        q_wr_q  <= push_s ? q_next(q_wr_q) : q_wr_q;
        q_rd_q  <= pop_s  ? q_next(q_rd_q) : q_rd_q;
        q_cnt_q <= q_cnt_q + QW'(push_s) - QW'(pop_s);
      end
    end
  end

  // Storage arrays; validity is tracked by the pointers above
  always_ff @(posedge clk) begin
    if (hs_s) begin
      pend_mem[pend_wr_q] <= fetch_pc_q;
    end
    if (push_s && !redirect_s) begin
      q_mem[q_wr_q] <= push_data_s;
    end
  end

  assign inst_sram_req   = issue_s;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_addr  = fetch_pc_q;
  assign inst_sram_wdata = 32'h0000_0000;
  assign fs_to_ds_valid  = valid_s;
  assign fs_to_ds_bus    = valid_s ? q_mem[q_rd_q] : 65'h0;

endmodule

// File: tb/tb_if_stage_multi.sv
module tb_if_stage_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_flush = 1'b0;
  logic [31:0] wb_target = 32'h0;
  logic        br_stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        ds_allowin = 1'b0;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'h0;

  int errors = 0;
  int checks = 0;
  int hs_total = 0;
  int max_out = 0;
  logic bus_hold = 1'b0;
  logic [31:0] bus_q[$];
  logic [64:0] exp_q[$];

  if_stage_multi dut (
    .clk(clk), .reset(reset),
    .wb_flush(wb_flush), .wb_target(wb_target),
    .br_stall(br_stall), .br_taken(br_taken), .br_target(br_target),
    .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address
  function automatic logic [31:0] mk(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_inst(input logic [31:0] pc);
    exp_q.push_back({1'b0, mk(pc), pc});
  endtask

  task automatic wait_hs(input int target, input string nm);
    int k = 0;
    while (hs_total < target && k < 200) begin
      cyc(1);
      k++;
    end
    check(nm, 65'(hs_total), 65'(target));
  endtask

  task automatic wait_empty(input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      cyc(1);
      k++;
    end
    check(nm, 65'(exp_q.size()), 65'd0);
    cyc(3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    addr_ok_low();
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic addr_ok_low();
    inst_sram_addr_ok = 1'b0;
  endtask

  // Bus model: records handshakes, answers one per cycle, one cycle later
  initial begin
    logic        s_hs;
    logic        s_resp;
    logic        s_rst;
    logic [31:0] s_addr;
    forever begin
      @(negedge clk);
      s_hs   = inst_sram_req & inst_sram_addr_ok;
      s_addr = inst_sram_addr;
      s_resp = inst_sram_data_ok;
      s_rst  = reset;
      @(posedge clk);
      #1;
      if (s_rst) begin
        bus_q.delete();
      end else begin
        if (s_resp && bus_q.size() > 0) void'(bus_q.pop_front());
        if (s_hs) begin
          bus_q.push_back(s_addr);
          hs_total++;
          if (bus_q.size() > max_out) max_out = bus_q.size();
        end
      end
      if (!s_rst && !bus_hold && bus_q.size() > 0) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = mk(bus_q[0]);
      end else begin
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
      end
    end
  end

  // Monitor: every accepted queue head is compared with the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (fs_to_ds_valid && ds_allowin) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL emit_unexpected: got %h expected nothing", fs_to_ds_bus);
        end else begin
          check("emit", fs_to_ds_bus, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    // Reset state
    cyc(1);
    @(negedge clk);
    check("rst_req", 65'(inst_sram_req), 65'd0);
    check("rst_valid", 65'(fs_to_ds_valid), 65'd0);
    check("rst_bus", fs_to_ds_bus, 65'd0);
    check("rst_addr", 65'(inst_sram_addr), 65'h1C00_0000);
    check("rst_size", 65'(inst_sram_size), 65'd2);
    check("rst_wr", 65'({inst_sram_wr, inst_sram_wstrb, inst_sram_wdata}), 65'd0);
    cyc(1);
    reset = 1'b0;

    // Streaming fetch
    expect_inst(32'h1C00_0000);
    expect_inst(32'h1C00_0004);
    expect_inst(32'h1C00_0008);
    ds_allowin = 1'b1;
    inst_sram_addr_ok = 1'b1;
    wait_hs(3, "stream_hs");
    inst_sram_addr_ok = 1'b0;
    wait_empty("stream_emit");
    check("stream_maxout", 65'(max_out <= 2), 65'd1);

    // Backpressure: queue of 4 fills, then one request per pop
    ds_allowin = 1'b0;
    base = hs_total;
    expect_inst(32'h1C00_000C);
    expect_inst(32'h1C00_0010);
    expect_inst(32'h1C00_0014);
    expect_inst(32'h1C00_0018);
    expect_inst(32'h1C00_001C);
    inst_sram_addr_ok = 1'b1;
    cyc(20);
    @(negedge clk);
    check("full_req", 65'(inst_sram_req), 65'd0);
    check("full_hs", 65'(hs_total - base), 65'd4);
    cyc(1);
    ds_allowin = 1'b1;
    cyc(1);
    ds_allowin = 1'b0;
    cyc(10);
    check("pop_refill_hs", 65'(hs_total - base), 65'd5);
    inst_sram_addr_ok = 1'b0;
    ds_allowin = 1'b1;
    wait_empty("full_emit");

    // Branch redirect with two requests in flight
    bus_hold = 1'b1;
    do_reset();
    base = hs_total;
    inst_sram_addr_ok = 1'b1;
    wait_hs(base + 2, "br_inflight_hs");
    cyc(3);
    @(negedge clk);
    check("br_outlimit_req", 65'(inst_sram_req), 65'd0);
    cyc(1);
    br_taken = 1'b1;
    br_target = 32'h1C00_0100;
    cyc(1);
    br_taken = 1'b0;
    @(negedge clk);
    check("br_addr", 65'(inst_sram_addr), 65'h1C00_0100);
    cyc(1);
    expect_inst(32'h1C00_0100);
    expect_inst(32'h1C00_0104);
    base = hs_total;
    bus_hold = 1'b0;
    wait_hs(base + 2, "br_refetch_hs");
    inst_sram_addr_ok = 1'b0;
    wait_empty("br_emit");
    check("br_discard_zero", 65'(dut.discard_cnt_q), 65'd0);

    // wb_flush and br_taken together, same cycle as a data_ok
    bus_hold = 1'b1;
    do_reset();
    base = hs_total;
    inst_sram_addr_ok = 1'b1;
    wait_hs(base + 2, "wb_inflight_hs");
    cyc(1);
    bus_hold = 1'b0;
    cyc(1);
    wb_flush = 1'b1;
    wb_target = 32'h1C00_8000;
    br_taken = 1'b1;
    br_target = 32'h1C00_0200;
    @(negedge clk);
    check("wb_valid_low", 65'(fs_to_ds_valid), 65'd0);
    cyc(1);
    wb_flush = 1'b0;
    br_taken = 1'b0;
    base = hs_total;
    expect_inst(32'h1C00_8000);
    expect_inst(32'h1C00_8004);
    @(negedge clk);
    check("wb_addr", 65'(inst_sram_addr), 65'h1C00_8000);
    wait_hs(base + 2, "wb_refetch_hs");
    inst_sram_addr_ok = 1'b0;
    wait_empty("wb_emit");

    // Misaligned branch target raises ADEF and halts fetch
    do_reset();
    ds_allowin = 1'b0;
    br_taken = 1'b1;
    br_target = 32'h1C00_0102;
    cyc(1);
    br_taken = 1'b0;
    exp_q.push_back({1'b1, 32'h0, 32'h1C00_0102});
    inst_sram_addr_ok = 1'b1;
    base = hs_total;
    @(negedge clk);
    check("adef_req", 65'(inst_sram_req), 65'd0);
    cyc(5);
    check("adef_no_hs", 65'(hs_total - base), 65'd0);
    ds_allowin = 1'b1;
    wait_empty("adef_emit");
    @(negedge clk);
    check("adef_halt_req", 65'(inst_sram_req), 65'd0);
    cyc(1);
    wb_flush = 1'b1;
    wb_target = 32'h1C00_8000;
    cyc(1);
    wb_flush = 1'b0;
    expect_inst(32'h1C00_8000);
    base = hs_total;
    wait_hs(base + 1, "adef_resume_hs");
    inst_sram_addr_ok = 1'b0;
    wait_empty("adef_resume_emit");

    // br_taken while br_stall is asserted is ignored and blocks issue
    inst_sram_addr_ok = 1'b1;
    br_stall = 1'b1;
    br_taken = 1'b1;
    br_target = 32'h1C00_0300;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req", 65'(inst_sram_req), 65'd0);
      cyc(1);
    end
    br_stall = 1'b0;
    br_taken = 1'b0;
    base = hs_total;
    expect_inst(32'h1C00_8004);
    @(negedge clk);
    check("stall_addr", 65'(inst_sram_addr), 65'h1C00_8004);
    wait_hs(base + 1, "stall_resume_hs");
    inst_sram_addr_ok = 1'b0;
    wait_empty("stall_emit");
    check("final_maxout", 65'(max_out <= 2), 65'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
